// File: rtl/sd_cmd_rx.sv
// -----------------------------------------------------------------------------
// sd_cmd_rx
// Passive sniffer for the SD bus CMD line. It watches host command frames and
// reports the index and argument of every well-formed one.
//
// The SD clock and CMD line are synchronised into the clk domain. CMD is
// sampled once per detected SD clock rising edge. A 48-bit frame is shifted in
// and its CRC7 is computed on the fly. One cycle after the end bit, the frame
// is judged:
//   - valid host frame  -> cmd_dat_o/arg_o updated, finsh_o pulses
//   - bad host frame    -> crc_err_o pulses, outputs held
//   - card response     -> ignored silently
// A frame is abandoned when the SD clock stalls for TIMEOUT clk cycles.
//
// Parameters
//   TIMEOUT    clk cycles without an SD clock edge before a frame is dropped
//   CHECK_CRC  1 = a CRC7 mismatch rejects the frame, 0 = the CRC is ignored
// Ports
//   clk        system clock (at least 4x the SD clock)
//   rst        asynchronous reset, active low
//   sd_clk_i   SD bus clock (asynchronous)
//   sd_cmd_i   SD CMD line (asynchronous)
//   cmd_dat_o  {2'b00, index} of the last valid frame
//   arg_o      argument of the last valid frame
//   finsh_o    one-cycle pulse per valid frame
//   crc_err_o  one-cycle pulse per rejected host frame
// -----------------------------------------------------------------------------
module sd_cmd_rx #(
   parameter int TIMEOUT   = 1024,
   parameter bit CHECK_CRC = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sd_clk_i,
   input  logic        sd_cmd_i,
   output logic [7:0]  cmd_dat_o,
   output logic [31:0] arg_o,
   output logic        finsh_o,
   output logic        crc_err_o
);

   typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

   localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

   state_t      state_reg;
   logic [1:0]  clk_sync_reg;
   logic [1:0]  cmd_sync_reg;
   logic        clk_prev_reg;
   logic [47:0] shift_reg;
   logic [5:0]  bit_cnt_reg;
   logic [15:0] idle_cnt_reg;
   logic [6:0]  crc_reg;

   logic        sd_edge;
   logic        sd_bit;
   logic [6:0]  crc_next;
   logic        crc_ok;
   logic        frame_valid;

   assign sd_edge = clk_sync_reg[1] & ~clk_prev_reg;
   assign sd_bit  = cmd_sync_reg[1];

   // Serial CRC7, generator x^7 + x^3 + 1
   assign crc_next = {crc_reg[5:0], 1'b0} ^ ({7{crc_reg[6] ^ sd_bit}} & 7'h09);

   // Frame fields as held in shift_reg once all 48 bits are in:
   // [47] start, [46] transmission, [45:40] index, [39:8] arg, [7:1] crc, [0] end
   assign crc_ok      = (crc_reg == shift_reg[7:1]) || !CHECK_CRC;
   assign frame_valid = shift_reg[46] && shift_reg[0] && crc_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         clk_sync_reg <= 2'b00;
         cmd_sync_reg <= 2'b00;
         clk_prev_reg <= 1'b0;
         shift_reg    <= 48'h0;
         bit_cnt_reg  <= 6'd0;
         idle_cnt_reg <= 16'd0;
         crc_reg      <= 7'h00;
         cmd_dat_o    <= 8'h00;
         arg_o        <= 32'h0;
         finsh_o      <= 1'b0;
         crc_err_o    <= 1'b0;
      end else begin
         clk_sync_reg <= {clk_sync_reg[0], sd_clk_i};
         cmd_sync_reg <= {cmd_sync_reg[0], sd_cmd_i};
         clk_prev_reg <= clk_sync_reg[1];

         // Pulses are single-cycle; only CHECK raises them
         finsh_o   <= 1'b0;
         crc_err_o <= 1'b0;

         case (state_reg)
            IDLE: begin
               idle_cnt_reg <= 16'd0;
               if (sd_edge && !sd_bit) begin
                  // The start bit is 0, so it leaves a zero CRC unchanged
                  shift_reg   <= {47'h0, sd_bit};
                  bit_cnt_reg <= 6'd1;
                  crc_reg     <= 7'h00;
                  state_reg   <= RECV;
               end
            end

            RECV: begin
               if (sd_edge) begin
                  idle_cnt_reg <= 16'd0;
                  shift_reg    <= {shift_reg[46:0], sd_bit};
                  bit_cnt_reg  <= bit_cnt_reg + 6'd1;
                  // CRC covers bits 0..39; bit 0 was absorbed in IDLE
                  if (bit_cnt_reg < 6'd40) begin
                     crc_reg <= crc_next;
                  end
                  if (bit_cnt_reg == 6'd47) begin
                     state_reg <= CHECK;
                  end
               end else if (idle_cnt_reg == IDLE_LAST) begin
                  // SD clock stalled: drop the partial frame quietly
                  idle_cnt_reg <= 16'd0;
                  bit_cnt_reg  <= 6'd0;
                  state_reg    <= IDLE;
               end else begin
                  idle_cnt_reg <= idle_cnt_reg + 16'd1;
               end
            end

            CHECK: begin
               if (frame_valid) begin
                  cmd_dat_o <= {2'b00, shift_reg[45:40]};
                  arg_o     <= shift_reg[39:8];
                  finsh_o   <= 1'b1;
               end else if (shift_reg[46]) begin
                  crc_err_o <= 1'b1;
               end
               bit_cnt_reg  <= 6'd0;
               idle_cnt_reg <= 16'd0;
               state_reg    <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_rx
// Directed bench for sd_cmd_rx. Two instances share the same bus: one checks
// the CRC and the other ignores it. A frame-level model predicts, for every
// complete frame sent, whether it must produce a finsh_o or a crc_err_o pulse
// and with what contents. A compare process checks the first instance against
// that model on every clk cycle.
// -----------------------------------------------------------------------------
module tb_sd_cmd_rx;

   localparam int TIMEOUT = 1024;

   logic        clk;
   logic        rst;
   logic        sd_clk;
   logic        sd_cmd;
   logic [7:0]  cmd_dat;
   logic [31:0] arg;
   logic        finsh;
   logic        crc_err;
   logic [7:0]  nc_cmd_dat;
   logic [31:0] nc_arg;
   logic        nc_finsh;
   logic        nc_crc_err;

   int checks = 0;
   int errors = 0;

   // Expected-event list: kind 1 = valid frame, 2 = rejected host frame
   int          exp_kind [32];
   logic [7:0]  exp_cmd  [32];
   logic [31:0] exp_arg  [32];
   int          wr_idx = 0;
   int          rd_idx = 0;
   logic [7:0]  m_cmd = 8'h00;
   logic [31:0] m_arg = 32'h0;
   int          nc_cnt = 0;

   sd_cmd_rx #(.TIMEOUT(TIMEOUT), .CHECK_CRC(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .sd_clk_i  (sd_clk),
      .sd_cmd_i  (sd_cmd),
      .cmd_dat_o (cmd_dat),
      .arg_o     (arg),
      .finsh_o   (finsh),
      .crc_err_o (crc_err)
   );

   sd_cmd_rx #(.TIMEOUT(TIMEOUT), .CHECK_CRC(1'b0)) dut_nc (
      .clk       (clk),
      .rst       (rst),
      .sd_clk_i  (sd_clk),
      .sd_cmd_i  (sd_cmd),
      .cmd_dat_o (nc_cmd_dat),
      .arg_o     (nc_arg),
      .finsh_o   (nc_finsh),
      .crc_err_o (nc_crc_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division)
   function automatic logic [6:0] crc7_model(input logic [39:0] msg);
      logic [46:0] r;
      logic [46:0] g;
      r = {msg, 7'h00};
      g = 47'h89;
      for (int i = 46; i >= 7; i--) begin
         if (r[i]) r = r ^ (g << (i - 7));
      end
      return r[6:0];
   endfunction

   // Predict the outcome of one complete 48-bit frame
   task automatic push_model(input logic [47:0] f);
      bit ok;
      if (f[46]) begin
         ok = f[0] && (crc7_model(f[47:8]) == f[7:1]);
         exp_kind[wr_idx % 32] = ok ? 1 : 2;
         exp_cmd[wr_idx % 32]  = {2'b00, f[45:40]};
         exp_arg[wr_idx % 32]  = f[39:8];
         wr_idx++;
      end
   endtask

   // SD clock at 8x slower than clk: 40 ns low, 40 ns high per bit
   task automatic send_bits(input logic [47:0] f, input int nbits);
      for (int i = 47; i > 47 - nbits; i--) begin
         sd_cmd = f[i];
         #40 sd_clk = 1'b1;
         #40 sd_clk = 1'b0;
      end
      sd_cmd = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      sd_cmd = 1'b1;
      for (int i = 0; i < n; i++) begin
         #40 sd_clk = 1'b1;
         #40 sd_clk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [47:0] f);
      push_model(f);
      $display("frame %h sent", f);
      send_bits(f, 48);
   endtask

   task automatic settle_and_check_pending(input string name);
      repeat (20) @(posedge clk);
      check(name, wr_idx - rd_idx, 0);
   endtask

   // Per-cycle compare of the CRC-checking instance against the model
   initial begin
      bit prev_f;
      bit prev_e;
      prev_f = 1'b0;
      prev_e = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            rd_idx = wr_idx;
            m_cmd  = 8'h00;
            m_arg  = 32'h0;
            check("reset_pulses", {30'h0, finsh, crc_err}, 32'h0);
         end else begin
            check("pulse_exclusive", {31'h0, finsh & crc_err}, 32'h0);
            if (finsh) begin
               check("finsh_width", {31'h0, prev_f}, 32'h0);
               if (rd_idx == wr_idx) begin
                  check("unexpected_finsh", 32'h1, 32'h0);
               end else begin
                  check("finsh_kind", exp_kind[rd_idx % 32], 1);
                  m_cmd = exp_cmd[rd_idx % 32];
                  m_arg = exp_arg[rd_idx % 32];
                  rd_idx++;
               end
            end
            if (crc_err) begin
               check("crc_err_width", {31'h0, prev_e}, 32'h0);
               if (rd_idx == wr_idx) begin
                  check("unexpected_crc_err", 32'h1, 32'h0);
               end else begin
                  check("crc_err_kind", exp_kind[rd_idx % 32], 2);
                  rd_idx++;
               end
            end
         end
         check("cmd_dat", {24'h0, cmd_dat}, {24'h0, m_cmd});
         check("arg", arg, m_arg);
         prev_f = finsh && rst;
         prev_e = crc_err && rst;
      end
   end

   // Pulse counter for the CRC-ignoring instance
   initial begin
      forever begin
         @(negedge clk);
         if (nc_finsh) nc_cnt++;
      end
   end

   initial begin
      int nc_before;
      rst    = 1'b0;
      sd_clk = 1'b0;
      sd_cmd = 1'b1;

      // Pin the model's CRC against known-good SD frames
      check("crc_pin_cmd8",  {25'h0, crc7_model(40'h48000001AA)}, 32'h43);
      check("crc_pin_cmd0",  {25'h0, crc7_model(40'h4000000000)}, 32'h4A);
      check("crc_pin_cmd17", {25'h0, crc7_model(40'h5100000000)}, 32'h2A);
      check("crc_pin_resp",  {25'h0, crc7_model(40'h08000001AA)}, 32'h09);

      repeat (4) @(negedge clk);
      check("rst_cmd_dat", {24'h0, cmd_dat}, 32'h0);
      check("rst_arg", arg, 32'h0);
      check("rst_finsh", {31'h0, finsh}, 32'h0);
      check("rst_crc_err", {31'h0, crc_err}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      idle_bits(4);

      // CMD8
      send_frame(48'h48_000001AA_87);
      settle_and_check_pending("cmd8_pending");
      check("cmd8_cmd_dat", {24'h0, cmd_dat}, 32'h08);
      check("cmd8_arg", arg, 32'h000001AA);
      idle_bits(3);

      // CMD0 then CMD17 back-to-back
      send_frame(48'h40_00000000_95);
      send_frame(48'h51_00000000_55);
      settle_and_check_pending("b2b_pending");
      check("b2b_cmd_dat", {24'h0, cmd_dat}, 32'h11);
      check("b2b_arg", arg, 32'h0);
      idle_bits(3);

      // CMD8 with a corrupted CRC
      nc_before = nc_cnt;
      send_frame(48'h48_000001AA_85);
      settle_and_check_pending("badcrc_pending");
      check("badcrc_cmd_held", {24'h0, cmd_dat}, 32'h11);
      check("nocrc_finsh_count", nc_cnt - nc_before, 1);
      check("nocrc_cmd_dat", {24'h0, nc_cmd_dat}, 32'h08);
      check("nocrc_arg", nc_arg, 32'h000001AA);
      idle_bits(3);

      // CMD0 with end bit 0
      send_frame(48'h40_00000000_94);
      settle_and_check_pending("badend_pending");
      idle_bits(3);

      // Card response: silently ignored by both instances
      nc_before = nc_cnt;
      send_frame(48'h08_000001AA_13);
      settle_and_check_pending("resp_pending");
      check("resp_nocrc_silent", nc_cnt - nc_before, 0);
      idle_bits(3);

      // Truncated frame, SD clock stalls past the timeout, then CMD0
      $display("frame 51_00000000_55 truncated after 20 bits");
      send_bits(48'h51_00000000_55, 20);
      repeat (TIMEOUT + 10) @(posedge clk);
      #1;
      send_frame(48'h40_00000000_95);
      settle_and_check_pending("timeout_pending");
      check("timeout_cmd_dat", {24'h0, cmd_dat}, 32'h00);
      idle_bits(3);

      // Put a non-zero value in the outputs so the reset check means something
      send_frame(48'h48_000001AA_87);
      settle_and_check_pending("pre_rst_pending");
      idle_bits(3);

      // Reset in the middle of a CMD17 frame
      $display("frame 51_00000000_55 interrupted by reset at bit 30");
      send_bits(48'h51_00000000_55, 30);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_cmd_dat", {24'h0, cmd_dat}, 32'h0);
      check("midrst_arg", arg, 32'h0);
      check("midrst_finsh", {31'h0, finsh}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      idle_bits(3);

      send_frame(48'h48_000001AA_87);
      settle_and_check_pending("post_rst_pending");
      check("post_rst_cmd_dat", {24'h0, cmd_dat}, 32'h08);
      check("post_rst_arg", arg, 32'h000001AA);

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
